// File: rtl/forward_source_pipe.sv
// Producer side of the forwarding protocol: decodes the D-stage destination and Tnew,
// carries it through E/M/W, publishes ready-qualified forward buses and a D-stage stall.
module forward_source_pipe #(
  parameter logic [1:0] ALU_TNEW  = 2'd1,
  parameter logic [1:0] LOAD_TNEW = 2'd2,
  parameter logic [1:0] LINK_TNEW = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [1:0]  use_bus_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        flush,
  output logic        stall_D,
  output logic [2:0]  forward_bus_E,
  output logic [2:0]  forward_bus_M,
  output logic [2:0]  forward_bus_W,
  output logic [4:0]  dst_E,
  output logic [4:0]  dst_M,
  output logic [4:0]  dst_W,
  output logic [1:0]  tnew_E,
  output logic [1:0]  tnew_M
);

  localparam logic [2:0] BUS_RD = 3'b100;
  localparam logic [2:0] BUS_RT = 3'b010;
  localparam logic [2:0] BUS_31 = 3'b001;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       alu_funct;

  logic [2:0] dec_bus;
  logic [4:0] dec_dst;
  logic [1:0] dec_tnew;

  logic [2:0] bus_E;
  logic [2:0] bus_M;
  logic [2:0] bus_W;

  logic hazard_rs;
  logic hazard_rt;
  logic unused_shamt;

  assign opcode       = IR_D[31:26];
  assign rs           = IR_D[25:21];
  assign rt           = IR_D[20:16];
  assign rd           = IR_D[15:11];
  assign funct        = IR_D[5:0];
  assign unused_shamt = ^IR_D[10:6];

  always_comb begin
    alu_funct = 1'b0;
    case (funct)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h10, 6'h12,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2a, 6'h2b: alu_funct = 1'b1;
      default:      alu_funct = 1'b0;
    endcase
  end

  // A decoded destination of $0 is never a producer, so it collapses to a full bubble.
  always_comb begin
    dec_bus  = 3'b000;
    dec_dst  = 5'd0;
    dec_tnew = 2'd0;
    case (opcode)
      6'h00: begin
        if (funct == 6'h09) begin
          dec_bus  = BUS_RD;
          dec_dst  = rd;
          dec_tnew = LINK_TNEW;
        end else if (alu_funct) begin
          dec_bus  = BUS_RD;
          dec_dst  = rd;
          dec_tnew = ALU_TNEW;
        end
      end
      6'h03: begin
        dec_bus  = BUS_31;
        dec_dst  = 5'd31;
        dec_tnew = LINK_TNEW;
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        dec_bus  = BUS_RT;
        dec_dst  = rt;
        dec_tnew = ALU_TNEW;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec_bus  = BUS_RT;
        dec_dst  = rt;
        dec_tnew = LOAD_TNEW;
      end
      default: ;
    endcase
    if (dec_dst == 5'd0) begin
      dec_bus  = 3'b000;
      dec_tnew = 2'd0;
    end
  end

  assign hazard_rs = use_bus_D[1] && (rs != 5'd0) &&
                     (((dst_E == rs) && (tnew_E > tuse_rs_D)) ||
                      ((dst_M == rs) && (tnew_M > tuse_rs_D)));
  assign hazard_rt = use_bus_D[0] && (rt != 5'd0) &&
                     (((dst_E == rt) && (tnew_E > tuse_rt_D)) ||
                      ((dst_M == rt) && (tnew_M > tuse_rt_D)));
  assign stall_D   = hazard_rs || hazard_rt;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      bus_E  <= 3'b000;
      dst_E  <= 5'd0;
      tnew_E <= 2'd0;
      bus_M  <= 3'b000;
      dst_M  <= 5'd0;
      tnew_M <= 2'd0;
      bus_W  <= 3'b000;
      dst_W  <= 5'd0;
    end else begin
      bus_W  <= bus_M;
      dst_W  <= dst_M;
      bus_M  <= bus_E;
      dst_M  <= dst_E;
      tnew_M <= (tnew_E == 2'd0) ? 2'd0 : tnew_E - 2'd1;
      if (stall_D) begin
        bus_E  <= 3'b000;
        dst_E  <= 5'd0;
        tnew_E <= 2'd0;
      end else begin
        bus_E  <= dec_bus;
        dst_E  <= dec_dst;
        tnew_E <= dec_tnew;
      end
    end
  end

  assign forward_bus_E = bus_E & {3{tnew_E == 2'd0}};
  assign forward_bus_M = bus_M & {3{tnew_M == 2'd0}};
  assign forward_bus_W = bus_W;

endmodule

// File: tb/tb_forward_source_pipe.sv
// Scoreboard bench for forward_source_pipe: each directed step queues its hand-computed
// expected outputs, and a negedge monitor pops and compares them.
module tb_forward_source_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] IR_D;
  logic [1:0]  use_bus_D;
  logic [1:0]  tuse_rs_D;
  logic [1:0]  tuse_rt_D;
  logic        flush;
  logic        stall_D;
  logic [2:0]  forward_bus_E;
  logic [2:0]  forward_bus_M;
  logic [2:0]  forward_bus_W;
  logic [4:0]  dst_E;
  logic [4:0]  dst_M;
  logic [4:0]  dst_W;
  logic [1:0]  tnew_E;
  logic [1:0]  tnew_M;

  forward_source_pipe dut (
    .clk           (clk),
    .reset         (reset),
    .IR_D          (IR_D),
    .use_bus_D     (use_bus_D),
    .tuse_rs_D     (tuse_rs_D),
    .tuse_rt_D     (tuse_rt_D),
    .flush         (flush),
    .stall_D       (stall_D),
    .forward_bus_E (forward_bus_E),
    .forward_bus_M (forward_bus_M),
    .forward_bus_W (forward_bus_W),
    .dst_E         (dst_E),
    .dst_M         (dst_M),
    .dst_W         (dst_W),
    .tnew_E        (tnew_E),
    .tnew_M        (tnew_M)
  );

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] LW8       = 32'h8C88_0000;
  localparam logic [31:0] ADDU9_8_1 = 32'h0101_4821;
  localparam logic [31:0] BEQ8_0    = 32'h1100_0000;
  localparam logic [31:0] JAL       = 32'h0C00_0000;
  localparam logic [31:0] ADDU9_31  = 32'h03E0_4821;
  localparam logic [31:0] ADDU0_1_2 = 32'h0022_0021;
  localparam logic [31:0] ADDU3_0_0 = 32'h0000_1821;
  localparam logic [31:0] LUI5      = 32'h3C05_0000;
  localparam logic [31:0] ADDU6_5   = 32'h00A0_3021;
  localparam logic [31:0] JALR7_2   = 32'h0040_3809;

  typedef struct {
    int         id;
    logic       stall;
    logic [2:0] fb_e;
    logic [2:0] fb_m;
    logic [2:0] fb_w;
    logic [4:0] d_e;
    logic [4:0] d_m;
    logic [4:0] d_w;
    logic [1:0] t_e;
    logic [1:0] t_m;
  } exp_t;

  exp_t sbq[$];
  int   testsRun;
  int   testsFailed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input int id, input logic st,
                              input logic [2:0] fe, input logic [2:0] fm, input logic [2:0] fw,
                              input logic [4:0] de, input logic [4:0] dm, input logic [4:0] dw,
                              input logic [1:0] te, input logic [1:0] tm);
    exp_t e;
    e.id = id; e.stall = st;
    e.fb_e = fe; e.fb_m = fm; e.fb_w = fw;
    e.d_e = de; e.d_m = dm; e.d_w = dw;
    e.t_e = te; e.t_m = tm;
    return e;
  endfunction

  // Inputs change just after the rising edge; the expectation describes what the
  // monitor should see at the following falling edge.
  task automatic applyStimulus(input logic rst, input logic fl, input logic [31:0] ir,
                               input logic [1:0] use_b, input logic [1:0] trs,
                               input logic [1:0] trt, input exp_t e);
    @(posedge clk);
    #1;
    reset     = rst;
    flush     = fl;
    IR_D      = ir;
    use_bus_D = use_b;
    tuse_rs_D = trs;
    tuse_rt_D = trt;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    testsRun++;
    if (stall_D !== e.stall || forward_bus_E !== e.fb_e || forward_bus_M !== e.fb_m ||
        forward_bus_W !== e.fb_w || dst_E !== e.d_e || dst_M !== e.d_m ||
        dst_W !== e.d_w || tnew_E !== e.t_e || tnew_M !== e.t_m) begin
      testsFailed++;
      $display("[TB] FAIL step%0d got stall=%b fb=%b/%b/%b dst=%0d/%0d/%0d tnew=%0d/%0d want stall=%b fb=%b/%b/%b dst=%0d/%0d/%0d tnew=%0d/%0d",
               e.id, stall_D, forward_bus_E, forward_bus_M, forward_bus_W,
               dst_E, dst_M, dst_W, tnew_E, tnew_M,
               e.stall, e.fb_e, e.fb_m, e.fb_w, e.d_e, e.d_m, e.d_w, e.t_e, e.t_m);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) checkOutput(sbq.pop_front());
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    flush       = 1'b0;
    IR_D        = NOP;
    use_bus_D   = 2'b00;
    tuse_rs_D   = 2'd0;
    tuse_rt_D   = 2'd0;

    applyStimulus(1, 0, NOP,       2'b00, 0, 0, mk(1,  0, 3'b000, 3'b000, 3'b000, 0,  0,  0,  0, 0));
    applyStimulus(0, 0, LW8,       2'b00, 0, 0, mk(2,  0, 3'b000, 3'b000, 3'b000, 0,  0,  0,  0, 0));
    applyStimulus(0, 0, ADDU9_8_1, 2'b11, 1, 1, mk(3,  1, 3'b000, 3'b000, 3'b000, 8,  0,  0,  2, 0));
    applyStimulus(0, 0, ADDU9_8_1, 2'b11, 1, 1, mk(4,  0, 3'b000, 3'b000, 3'b000, 0,  8,  0,  0, 1));
    applyStimulus(0, 0, NOP,       2'b00, 0, 0, mk(5,  0, 3'b000, 3'b000, 3'b010, 9,  0,  8,  1, 0));
    applyStimulus(0, 0, LW8,       2'b00, 0, 0, mk(6,  0, 3'b000, 3'b100, 3'b000, 0,  9,  0,  0, 0));
    applyStimulus(0, 0, BEQ8_0,    2'b11, 0, 0, mk(7,  1, 3'b000, 3'b000, 3'b100, 8,  0,  9,  2, 0));
    applyStimulus(0, 0, BEQ8_0,    2'b11, 0, 0, mk(8,  1, 3'b000, 3'b000, 3'b000, 0,  8,  0,  0, 1));
    applyStimulus(0, 0, BEQ8_0,    2'b11, 0, 0, mk(9,  0, 3'b000, 3'b000, 3'b010, 0,  0,  8,  0, 0));
    applyStimulus(0, 0, JAL,       2'b00, 0, 0, mk(10, 0, 3'b000, 3'b000, 3'b000, 0,  0,  0,  0, 0));
    applyStimulus(0, 0, ADDU9_31,  2'b10, 0, 0, mk(11, 0, 3'b001, 3'b000, 3'b000, 31, 0,  0,  0, 0));
    applyStimulus(0, 0, ADDU0_1_2, 2'b00, 0, 0, mk(12, 0, 3'b000, 3'b001, 3'b000, 9,  31, 0,  1, 0));
    applyStimulus(0, 0, ADDU3_0_0, 2'b11, 0, 0, mk(13, 0, 3'b000, 3'b100, 3'b001, 0,  9,  31, 0, 0));
    applyStimulus(0, 0, LW8,       2'b00, 0, 0, mk(14, 0, 3'b000, 3'b000, 3'b100, 3,  0,  9,  1, 0));
    applyStimulus(0, 1, ADDU9_8_1, 2'b11, 1, 1, mk(15, 1, 3'b000, 3'b100, 3'b000, 8,  3,  0,  2, 0));
    applyStimulus(0, 0, ADDU9_8_1, 2'b11, 1, 1, mk(16, 0, 3'b000, 3'b000, 3'b000, 0,  0,  0,  0, 0));
    applyStimulus(0, 0, LUI5,      2'b00, 0, 0, mk(17, 0, 3'b000, 3'b000, 3'b000, 9,  0,  0,  1, 0));
    applyStimulus(0, 0, ADDU6_5,   2'b10, 0, 0, mk(18, 1, 3'b000, 3'b100, 3'b000, 5,  9,  0,  1, 0));
    applyStimulus(1, 0, ADDU6_5,   2'b10, 0, 0, mk(19, 0, 3'b000, 3'b010, 3'b100, 0,  5,  9,  0, 0));
    applyStimulus(0, 0, JALR7_2,   2'b00, 0, 0, mk(20, 0, 3'b000, 3'b000, 3'b000, 0,  0,  0,  0, 0));
    applyStimulus(0, 0, NOP,       2'b00, 0, 0, mk(21, 0, 3'b100, 3'b000, 3'b000, 7,  0,  0,  0, 0));
    applyStimulus(0, 0, NOP,       2'b00, 0, 0, mk(22, 0, 3'b000, 3'b100, 3'b000, 0,  7,  0,  0, 0));

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      testsFailed++;
      $display("[TB] FAIL drain got %0d pending want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
